dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning data-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 4, per-core access request; bit i = core i.
REQ-006 The block SHALL have port we, input, 4, per-core write flag: 1 = write, 0 = read.
REQ-007 The block SHALL have ports addr1..addr4, input, ADDR_W each, per-core address.
REQ-008 The block SHALL have ports wdata1..wdata4, input, DATA_W each, per-core write data.
REQ-009 The block SHALL have port gnt, output, 4, one-hot grant pulse.
REQ-010 The block SHALL have port rvalid, output, 4, one-hot read-data-valid pulse.
REQ-011 The block SHALL have port rdata, output, DATA_W, read data shared by all cores.
REQ-012 The block SHALL have ports mem_addr (out, ADDR_W), mem_we (out, 1), mem_wdata (out, DATA_W) and mem_rdata (in, DATA_W), driving a single-port RAM with 1-cycle registered read.
REQ-013 The block SHALL have port stall_cnt, output, 16, saturating count of wait cycles (see Configuration).

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCESS and RESP; it is in IDLE after reset.
REQ-015 IDLE: if req!=0, the winner SHALL be the first set bit scanning up from rr_ptr, mod 4; winner id, we, addr and wdata latched; next state ACCESS. If req==0, stay in IDLE.
REQ-016 ACCESS: gnt[winner]=1 for exactly this cycle; mem_addr/mem_wdata = latched values; mem_we = latched_we & ~rst. Next state IDLE if write, RESP if read.
REQ-017 RESP: rvalid[winner]=1 for exactly this cycle; rdata = mem_rdata (combinational pass-through). Next state IDLE.
REQ-018 Latency SHALL be: write, req seen in IDLE at cycle t -> gnt at t+1; read, gnt at t+1 and rvalid at t+2; throughput 2 cycles/write, 3 cycles/read.
REQ-019 rr_ptr SHALL update to (winner+1) mod 4 on each IDLE->ACCESS transition; it is 0 after reset.
REQ-020 Core protocol: a core SHALL hold req, we, addr and wdata stable until gnt (write) or rvalid (read), and deassert req on the next edge.
REQ-021 Changes to req/addr/we/wdata after latching SHALL NOT affect the in-flight access, including the winner dropping req.
REQ-022 Outside ACCESS, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last latched values.
REQ-023 Outside RESP, rdata SHALL be 0; gnt and rvalid SHALL be 0 in every state not listed above.
REQ-024 Simultaneous requests from all four cores SHALL each be served within 4 arbitration rounds; no core starves.

Reset
REQ-025 rst SHALL force, on the next edge: state=IDLE, rr_ptr=0, latched fields=0, stall_cnt=0.
REQ-026 While rst=1, gnt=0, rvalid=0, mem_we=0 and rdata=0.
REQ-027 rst asserted during ACCESS SHALL suppress that cycle's write; rst asserted during RESP SHALL drop the rvalid pulse.

Configuration
REQ-028 Macro DMEM_ARB_STATS_EN defined: stall_cnt SHALL increment by 1, saturating at 16'hFFFF, each cycle in which any req bit is set that is not the bit granted that cycle.
REQ-029 Macro DMEM_ARB_STATS_EN undefined: stall_cnt SHALL be constant 0, with no counter logic.

Verification
REQ-030 Single write: core2 req, we=1, addr=8'h10, wdata=16'hABCD -> gnt=4'b0100 one cycle later, mem_we=1, mem_addr=8'h10, mem_wdata=16'hABCD; RAM[8'h10]=16'hABCD.
REQ-031 Single read: after REQ-030, core0 reads addr 8'h10 -> gnt=4'b0001 at t+1, rvalid=4'b0001 and rdata=16'hABCD at t+2.
REQ-032 All four cores request writes at once from reset -> grant order is core0, core1, core2, core3, every 2 cycles; no gnt overlap.
REQ-033 rst asserted in the ACCESS cycle of a write of 16'h1234 to 8'h20 -> mem_we=0; RAM[8'h20] unchanged; state IDLE; outputs 0.
REQ-034 With DMEM_ARB_STATS_EN, cores 1 and 3 request reads at once -> core1 served first; core3 waits 3 cycles; stall_cnt=3 after both complete.
REQ-035 Without DMEM_ARB_STATS_EN, same stimulus as REQ-034 -> stall_cnt=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that lets four cores share one single-port
// data RAM with a 1-cycle registered read.
//
// Optional build macro: DMEM_ARB_STATS_EN. When it is defined, stall_cnt counts
// the cycles in which some requesting core is kept waiting. When it is left
// undefined, stall_cnt is tied to 0 and no counter is built.
//
// Handshake: a core raises req[i], together with we[i], addr and wdata, and
// holds all of them stable. A write finishes on the cycle gnt[i] is high. A
// read finishes on the cycle rvalid[i] is high, and rdata is valid only in that
// cycle. The core drops req[i] on the following edge. Once the arbiter has
// latched a request, later changes on the core inputs do not affect it.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [ADDR_W-1:0] addr4,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [DATA_W-1:0] wdata3,
    input  logic [DATA_W-1:0] wdata4,
    output logic [3:0]        gnt,
    output logic [3:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [1:0]        winner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [1:0]        pick;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Round-robin pick. The scan runs from offset 3 down to 0, so the set bit
    // nearest to rr_ptr is written last and wins.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (req[idx]) pick = idx;
        end
    end

    // Route the picked core's address and write data toward the latches.
    always_comb begin
        sel_addr  = addr1;
        sel_wdata = wdata1;
        case (pick)
            2'd0: begin sel_addr = addr1; sel_wdata = wdata1; end
            2'd1: begin sel_addr = addr2; sel_wdata = wdata2; end
            2'd2: begin sel_addr = addr3; sel_wdata = wdata3; end
            default: begin sel_addr = addr4; sel_wdata = wdata4; end
        endcase
    end

    // Control FSM. IDLE latches the winning request, ACCESS drives the RAM,
    // and RESP returns read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner    <= pick;
                        lat_we    <= we[pick];
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        rr_ptr    <= pick + 2'd1;
                        state     <= ACCESS;
                    end
                end
                ACCESS:  state <= lat_we ? IDLE : RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pulses are decoded from the state, and rst gates them. A reset that lands
    // in ACCESS or RESP therefore kills that cycle's write or rvalid pulse.
    assign gnt       = (state == ACCESS && !rst) ? (4'b0001 << winner) : 4'b0000;
    assign rvalid    = (state == RESP && !rst)   ? (4'b0001 << winner) : 4'b0000;
    assign rdata     = (state == RESP && !rst)   ? mem_rdata : '0;
    assign mem_we    = (state == ACCESS) & lat_we & ~rst;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign fsm_state = state;

`ifdef DMEM_ARB_STATS_EN
    // The owner of a cycle is the core picked this cycle when in IDLE, or the
    // in-flight winner in ACCESS/RESP. Any other pending request is a stall.
    logic [1:0] owner;
    logic       stall;
    assign owner = (state == IDLE) ? pick : winner;
    assign stall = |(req & ~(4'b0001 << owner));

    // Saturating count of stall cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural RAM.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [7:0]  addr1, addr2, addr3, addr4;
    logic [15:0] wdata1, wdata2, wdata3, wdata4;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [15:0] rdata;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] stall_cnt;
    logic [1:0]  fsm_state;

    logic [15:0] ram [0:255];
    logic [1:0]  exp_q[$];
    logic [15:0] exp_d[$];
    int          n_checks;
    int          n_pass;
    logic [3:0]  hold;
    int          last_cyc;
    int          n_seen;
    logic [15:0] exp_stall;
    logic [15:0] wr_tbl [0:3];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
        .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3), .wdata4(wdata4),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt), .fsm_state(fsm_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with a registered read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        we  = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        ram[8'h20] = 16'h5555;
        mem_rdata = '0;
        rst = 1'b1; req = '0; we = '0;
        addr1 = '0; addr2 = '0; addr3 = '0; addr4 = '0;
        wdata1 = '0; wdata2 = '0; wdata3 = '0; wdata4 = '0;
        wr_tbl[0] = 16'h1111; wr_tbl[1] = 16'h2222; wr_tbl[2] = 16'h3333; wr_tbl[3] = 16'h4444;

        // Reset state, with requests already pending while rst is high.
        next_cycle();
        req = 4'b1111;
        next_cycle();
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rdata", rdata, 0);
        check("rst_state", fsm_state, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_stall", stall_cnt, 0);
        do_reset();

        // Single write from core2.
        req = 4'b0100; we = 4'b0100; addr3 = 8'h10; wdata3 = 16'hABCD;
        @(negedge clk);
        check("wr_idle_gnt", gnt, 0);
        next_cycle();
        @(negedge clk);
        check("wr_gnt", gnt, 4'b0100);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 8'h10);
        check("wr_mem_wdata", mem_wdata, 16'hABCD);
        check("wr_rvalid", rvalid, 0);
        // Core2 drops its request. Core0 starts a read of the same address.
        next_cycle();
        req = 4'b0001; we = 4'b0000; addr1 = 8'h10;
        @(negedge clk);
        check("wr_gnt_done", gnt, 0);
        check("wr_we_low", mem_we, 0);
        check("wr_addr_hold", mem_addr, 8'h10);
        check("wr_ram", ram[8'h10], 16'hABCD);
        // ACCESS of the read. Core0 changes its inputs and must not disturb it.
        next_cycle();
        addr1 = 8'h99; req = 4'b0000;
        @(negedge clk);
        check("rd_gnt", gnt, 4'b0001);
        check("rd_mem_we", mem_we, 0);
        check("rd_mem_addr", mem_addr, 8'h10);
        check("rd_rdata_zero", rdata, 0);
        check("rd_rvalid_early", rvalid, 0);
        next_cycle();
        @(negedge clk);
        check("rd_rvalid", rvalid, 4'b0001);
        check("rd_rdata", rdata, 16'hABCD);
        check("rd_gnt_low", gnt, 0);
        next_cycle();
        @(negedge clk);
        check("rd_rvalid_done", rvalid, 0);
        check("rd_rdata_done", rdata, 0);
        check("rd_state_idle", fsm_state, 0);

        // All four cores write at once: expect grants to cores 0,1,2,3, two cycles apart.
        do_reset();
        addr1 = 8'h30; addr2 = 8'h31; addr3 = 8'h32; addr4 = 8'h33;
        wdata1 = wr_tbl[0]; wdata2 = wr_tbl[1]; wdata3 = wr_tbl[2]; wdata4 = wr_tbl[3];
        req = 4'b1111; we = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
        hold = '0; last_cyc = 0; n_seen = 0;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            next_cycle();
            req = req & ~hold;
            @(negedge clk);
            hold = gnt;
            if (gnt != 0) begin
                check("wr4_gnt", gnt, 4'b0001 << exp_q.pop_front());
                if (n_seen > 0) check("wr4_gap", cyc - last_cyc, 2);
                last_cyc = cyc;
                n_seen++;
            end
        end
        check("wr4_all_granted", exp_q.size(), 0);
        next_cycle();
        req = '0; we = '0;
        for (int k = 0; k < 4; k++) check("wr4_ram", ram[8'h30 + k], wr_tbl[k]);

        // Reset lands in the ACCESS cycle of a write: the write must be suppressed.
        do_reset();
        req = 4'b0001; we = 4'b0001; addr1 = 8'h20; wdata1 = 16'h1234;
        next_cycle();
        rst = 1'b1; req = '0; we = '0;
        @(negedge clk);
        check("rstacc_mem_we", mem_we, 0);
        check("rstacc_gnt", gnt, 0);
        check("rstacc_rvalid", rvalid, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstacc_ram", ram[8'h20], 16'h5555);
        check("rstacc_state", fsm_state, 0);
        check("rstacc_mem_addr", mem_addr, 0);
        check("rstacc_mem_wdata", mem_wdata, 0);
        check("rstacc_gnt_after", gnt, 0);

        // Reset lands in RESP: the rvalid pulse must be dropped.
        req = 4'b0001; we = 4'b0000; addr1 = 8'h10;
        next_cycle();
        next_cycle();
        rst = 1'b1; req = '0;
        @(negedge clk);
        check("rstresp_rvalid", rvalid, 0);
        check("rstresp_rdata", rdata, 0);
        next_cycle();
        rst = 1'b0;

        // Cores 1 and 3 read at once: core1 is served first and core3 waits 3 cycles.
        do_reset();
        addr2 = 8'h10; addr4 = 8'h33;
        req = 4'b1010; we = 4'b0000;
        exp_q.push_back(2'd1); exp_d.push_back(16'hABCD);
        exp_q.push_back(2'd3); exp_d.push_back(16'h4444);
        hold = '0;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            next_cycle();
            req = req & ~hold;
            @(negedge clk);
            hold = rvalid;
            if (rvalid != 0) begin
                check("rd2_rvalid", rvalid, 4'b0001 << exp_q.pop_front());
                check("rd2_rdata", rdata, exp_d.pop_front());
            end
        end
        check("rd2_all_served", exp_q.size(), 0);
`ifdef DMEM_ARB_STATS_EN
        exp_stall = 16'd3;
`else
        exp_stall = 16'd0;
`endif
        check("rd2_stall", stall_cnt, exp_stall);
        next_cycle();
        req = req & ~hold;
        @(negedge clk);
        check("rd2_stall_final", stall_cnt, exp_stall);
        check("rd2_idle", fsm_state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
